// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scanner
package seg_pkg;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;
    // active-low glyphs a..g in bits 7:1, dp bit left off
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: nibble plus dp to active-low segment pattern, with glyph suppression
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       suppress,
    output logic [7:0] seg
);
    // suppressed digits keep a-g dark but still show their decimal point
    always_comb begin
        seg = suppress ? SEG_OFF : HEX_SEG[nibble];
        seg[SEG_DP] = ~dp;
    end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment scanner with frame-aligned double buffering
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SCAN_CYCLES = 100000,
    parameter int GUARD       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     TopNumEN,
    output logic [7:0]            TopNum,
    output logic                  frame_done
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int IW = $clog2(DIGITS);

    logic [SW-1:0]         slot_cnt;
    logic [IW-1:0]         idx;
    logic [3:0]            pwm_cnt;
    logic [4*DIGITS-1:0]   act_data, pend_data;
    logic [DIGITS-1:0]     act_dp, pend_dp, act_blank, pend_blank;
    logic                  pend_flag;
    logic                  slot_end, boundary, lit, lz;
    logic [7:0]            seg;

    assign slot_end = slot_cnt == SW'(SCAN_CYCLES - 1);
    assign boundary = slot_end && idx == IW'(DIGITS - 1);
    assign lit      = slot_cnt >= SW'(GUARD) && pwm_cnt <= bright && !act_blank[idx];

    // a digit is a leading zero when it and every visible higher digit are zero
    always_comb begin
        lz = lz_en && idx != '0;
        for (int j = 0; j < DIGITS; j++)
            if (j >= int'(idx) && !act_blank[j] && act_data[4*j +: 4] != 4'h0) lz = 1'b0;
    end

    seg_hex_decoder u_dec (
        .nibble   (act_data[{idx, 2'b00} +: 4]),
        .dp       (act_dp[idx]),
        .suppress (lz),
        .seg      (seg)
    );

    // slot, digit and PWM counters
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            slot_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
            idx      <= slot_end ? (idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
            pwm_cnt  <= pwm_cnt + 4'd1;
        end

    // pending buffer captures loads; active buffer swaps only at the frame boundary
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pend_flag  <= 1'b0;
        end else begin
            if (boundary && pend_flag) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_mask;
                pend_blank <= blank_mask;
            end
            pend_flag <= load || (pend_flag && !boundary);
        end

    // registered pin drivers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            TopNumEN   <= '1;
            TopNum     <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            TopNumEN   <= lit ? ~(DIGITS'(1) << idx) : '1;
            TopNum     <= lit ? seg : SEG_OFF;
            frame_done <= boundary;
        end
endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multiplexed seven-segment scanner; next generation of the board display driver. Drives DIGITS common-anode digits from one packed hex word with per-digit decimal point, per-digit blanking, leading-zero suppression and 16-level PWM brightness. Loads are double-buffered and take effect only at a frame boundary, so the display never tears. Sits between the CPU debug/status registers and the board TopNumEN/TopNum pins.

Parameters:
DIGITS, 8, number of digits scanned (2..16)
SCAN_CYCLES, 100000, clock cycles each digit is selected (>= 2*GUARD+16)
GUARD, 16, cycles at the start of each slot with all enables off (anti-ghosting)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load  in  1  single-cycle strobe: capture data/dp_mask/blank_mask into pending buffer
data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
dp_mask  in  DIGITS  1 = decimal point lit on digit i
blank_mask  in  DIGITS  1 = digit i fully off
lz_en  in  1  leading-zero suppression enable (live, not buffered)
bright  in  4  duty level, 0 = 1/16, 15 = always on (live)
TopNumEN  out  DIGITS  digit enables, active-low, one-hot-low or all ones
TopNum  out  8  segments active-low, bit7=a .. bit1=g, bit0=dp
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- One clock; reset is asynchronous and active-high. Reset values: TopNumEN all ones, TopNum 8'hFF, frame_done 0, slot counter 0, digit index 0, PWM counter 0, active and pending data 0, active and pending blank_mask all ones, dp 0, pending flag 0. Display is dark until the first load reaches a frame boundary.
- slot_cnt counts 0..SCAN_CYCLES-1 and wraps. On wrap, digit index advances by 1; it wraps DIGITS-1 -> 0.
- Frame boundary is the cycle where slot_cnt = SCAN_CYCLES-1 and index = DIGITS-1. In that cycle, if the pending flag is set, active <= pending and the flag clears. frame_done is asserted for that boundary.
- load captures inputs into pending and sets the flag. A load in the boundary cycle writes pending, and the flag stays set. The active buffer takes the previous pending contents; the new value applies at the next boundary. Back-to-back loads: the last one wins.
- pwm_cnt is a free-running 4-bit counter, incremented every clock. The lit condition for the current digit is: slot_cnt >= GUARD, pwm_cnt <= bright, and active blank bit = 0. When lit, its TopNumEN bit is 0; otherwise TopNumEN is all ones.
- Segments come from the hex decoder; 0..F use standard glyphs (0 = 8'b00000011, 8 = 8'b00000001, F = 8'b01110001). The dp bit is 0 when the active dp bit is set.
- Leading-zero suppression applies when lz_en = 1, i > 0, and nibble i plus all higher non-blanked nibbles are zero. In that case bits 7:1 = 1 (a-g off); dp is still honoured.
- Outputs are registered, with one cycle of latency from the counter state. TopNum = 8'hFF whenever TopNumEN is all ones.
- Reset mid-frame: all outputs are forced immediately to reset values and any pending load is discarded.

Decomposition:
- Package seg_pkg: SEG_OFF = 8'hFF, the 16-entry hex-to-segment constant table, segment bit-position constants.
- Sub-module seg_hex_decoder: combinational, 4-bit nibble plus dp in, 8-bit active-low segments out. The scanner instantiates one copy after the digit mux.

Test Plan:
Sim config is DIGITS=4, SCAN_CYCLES=32, GUARD=2.
- Reset release, no load -> TopNumEN=4'hF and TopNum=8'hFF for a full frame; frame_done pulses every 128 cycles.
- load data=16'h12A0, dp=0, blank=0, bright=15 -> after the next boundary the slots show digit0 0x03, digit1 0x11, digit2 0x25, digit3 0x9F. Each slot shows enables 4'hF for 2 cycles, then 1110/1101/1011/0111.
- data=16'h0005, lz_en=1 -> digits 3..1 show TopNum=8'hFF with enable low, digit0 shows 0x49. With dp_mask=4'b0100, digit2 shows 8'hFE.
- bright=3 -> within a slot after GUARD, the enable is low exactly 4 of every 16 cycles, aligned to pwm_cnt 0..3.
- load 16'h1111 then 16'h2222 in one frame, with a third load in the boundary cycle -> the next frame shows 2222, and the third value appears one frame later.
- Assert rst mid-slot, digit 2 -> outputs go to all ones in the same cycle; after release, scanning restarts at digit 0 with the display dark.
